// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared RV32I constants and types for the R-type execution sequencer:
//   - major opcode and funct7 encodings
//   - ALU operation codes driven on alu_op
//   - FSM state type and state constants
// ---------------------------------------------------------------------------
package rv_pkg;

    // Major opcode for register-register ALU instructions
    localparam logic [6:0] OPC_RTYPE = 7'b0110011;

    // funct7 values. F7_ALT selects SUB and SRA.
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    // ALU operation encodings
    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 4'd0;
    localparam alu_op_t ALU_SUB  = 4'd1;
    localparam alu_op_t ALU_SLL  = 4'd2;
    localparam alu_op_t ALU_SLT  = 4'd3;
    localparam alu_op_t ALU_SLTU = 4'd4;
    localparam alu_op_t ALU_XOR  = 4'd5;
    localparam alu_op_t ALU_SRL  = 4'd6;
    localparam alu_op_t ALU_SRA  = 4'd7;
    localparam alu_op_t ALU_OR   = 4'd8;
    localparam alu_op_t ALU_AND  = 4'd9;

    // Sequencer FSM states. These are kept as plain constants so the
    // encoding matches the legacy design.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_DECODE = 3'd1;
    localparam state_t ST_READ   = 3'd2;
    localparam state_t ST_EXEC   = 3'd3;
    localparam state_t ST_WB     = 3'd4;

endpackage

// File: rtl/r_exec_sequencer_if.sv
// ---------------------------------------------------------------------------
// r_exec_sequencer_if
// Fetch-to-sequencer instruction handshake.
//   instr_valid : fetch presents instr_word
//   instr_word  : 32-bit instruction word
//   instr_ready : sequencer can accept an instruction
// A word transfers on a rising edge where instr_valid && instr_ready.
// Modports:
//   master : fetch side (drives valid/word)
//   slave  : sequencer side (drives ready)
// ---------------------------------------------------------------------------
interface r_exec_sequencer_if;

    logic        instr_valid;
    logic [31:0] instr_word;
    logic        instr_ready;

    modport master (
        output instr_valid,
        output instr_word,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_word,
        output instr_ready
    );

endinterface

// File: rtl/r_field_decode.sv
// ---------------------------------------------------------------------------
// r_field_decode
// Combinational R-type decoder. It slices the register fields, checks the
// encoding for legality and maps funct3/funct7 onto an ALU operation.
// Ports:
//   instr_word : in  32  instruction word
//   rs1        : out 5   source register A   [19:15]
//   rs2        : out 5   source register B   [24:20]
//   rd         : out 5   destination         [11:7]
//   legal      : out 1   word is a supported R-type encoding
//   alu_op     : out 4   ALU operation code (ADD when nothing else applies)
// ---------------------------------------------------------------------------
module r_field_decode
    import rv_pkg::*;
(
    input  logic [31:0] instr_word,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        legal,
    output alu_op_t     alu_op
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr_word[6:0];
    assign rd     = instr_word[11:7];
    assign funct3 = instr_word[14:12];
    assign rs1    = instr_word[19:15];
    assign rs2    = instr_word[24:20];
    assign funct7 = instr_word[31:25];

    // Only ADD/SUB and SRL/SRA have an alternate funct7 form.
    always_comb begin
        legal = 1'b0;
        if (opcode == OPC_RTYPE) begin
            if (funct7 == F7_BASE) begin
                legal = 1'b1;
            end else if (funct7 == F7_ALT &&
                         (funct3 == 3'b000 || funct3 == 3'b101)) begin
                legal = 1'b1;
            end
        end
    end

    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'b000:  alu_op = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/r_exec_sequencer.sv
// ---------------------------------------------------------------------------
// r_exec_sequencer
// Multi-cycle control FSM that steps R-type instructions through the RV32I
// register file and ALU: IDLE -> DECODE -> READ -> EXEC -> WB -> IDLE.
// Illegal encodings pulse illegal_instr in DECODE and return to IDLE.
// Ports:
//   clk           : in  1      system clock, rising edge
//   rst_n         : in  1      asynchronous active-low reset
//   fetch         : slave      instr_valid / instr_word / instr_ready
//   rf_rs1_addr   : out 5      register-file read address A
//   rf_rs2_addr   : out 5      register-file read address B
//   rf_re         : out 1      register-file read enable (READ)
//   alu_op        : out 4      ALU operation code
//   alu_en        : out 1      ALU operate strobe (EXEC)
//   rf_rd_addr    : out 5      writeback address
//   rf_we         : out 1      writeback enable (WB, not stalled, rd != 0)
//   wb_stall      : in  1      writeback port busy; hold in WB
//   illegal_instr : out 1      one-cycle pulse on an illegal encoding
//   busy          : out 1      high in any state other than IDLE
//   retired_cnt   : out CNT_W  completed legal instructions, wraps
// ---------------------------------------------------------------------------
module r_exec_sequencer
    import rv_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    r_exec_sequencer_if.slave  fetch,
    output logic [4:0]         rf_rs1_addr,
    output logic [4:0]         rf_rs2_addr,
    output logic               rf_re,
    output logic [3:0]         alu_op,
    output logic               alu_en,
    output logic [4:0]         rf_rd_addr,
    output logic               rf_we,
    input  logic               wb_stall,
    output logic               illegal_instr,
    output logic               busy,
    output logic [CNT_W-1:0]   retired_cnt
);

    state_t      state;
    state_t      state_next;

    // Captured instruction word. All field outputs are slices of this
    // register, so the register addresses stay stable from DECODE through
    // WB without separate holding registers.
    logic [31:0] instr_q;

    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_legal;
    alu_op_t     dec_alu_op;

    logic        accept;
    logic        retire;

    r_field_decode u_decode (
        .instr_word (instr_q),
        .rs1        (dec_rs1),
        .rs2        (dec_rs2),
        .rd         (dec_rd),
        .legal      (dec_legal),
        .alu_op     (dec_alu_op)
    );

    assign accept = (state == ST_IDLE) && fetch.instr_valid;
    assign retire = (state == ST_WB) && !wb_stall;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (fetch.instr_valid) state_next = ST_DECODE;
            ST_DECODE: state_next = dec_legal ? ST_READ : ST_IDLE;
            ST_READ:   state_next = ST_EXEC;
            ST_EXEC:   state_next = ST_WB;
            ST_WB:     if (!wb_stall) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            instr_q     <= '0;
            retired_cnt <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                instr_q <= fetch.instr_word;
            end
            if (retire) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

    // Strobes are decoded from the registered state, so an asynchronous
    // reset forces them all low immediately.
    assign fetch.instr_ready = (state == ST_IDLE);
    assign busy              = (state != ST_IDLE);
    assign illegal_instr     = (state == ST_DECODE) && !dec_legal;
    assign rf_re             = (state == ST_READ);
    assign alu_en            = (state == ST_EXEC);
    // x0 is hardwired to zero, so rd == 0 retires without a write.
    assign rf_we             = retire && (dec_rd != 5'd0);

    assign rf_rs1_addr       = dec_rs1;
    assign rf_rs2_addr       = dec_rs2;
    assign rf_rd_addr        = dec_rd;
    assign alu_op            = dec_alu_op;

endmodule
